pr_arbiter: RTL and testbench

- Sequential arbiter that shares one downstream resource between N_REQ requesters.
- Winner is chosen by big-endian priority: highest requester index wins.
- Once granted, the owner keeps the grant until it releases; a one-cycle turnaround follows every grant.
- Sits between requesting masters and the shared datapath; its encoder core uses the team's standard MSB-first encoding rule.

---
 rtl/pr_arb_pkg.sv | 13 +
 rtl/pr_enc_core.sv | 26 ++
 rtl/pr_arbiter.sv | 137 +++++++++++++
 tb/tb_pr_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pr_arb_pkg.sv
// Shared types and default constants for the priority arbiter.
package pr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    localparam int N_REQ_DEF    = 8;
    localparam int MAX_HOLD_DEF = 16;

endpackage

// File: rtl/pr_enc_core.sv
// MSB-first priority encoder: returns the highest set index of vec and
// whether any bit was set at all.
module pr_enc_core
    import pr_arb_pkg::*;
#(
    parameter int N   = N_REQ_DEF,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   vec,
    output logic [IDW-1:0] idx,
    output logic           any_valid
);

    // Ascending scan so the last (highest) set bit overwrites lower ones.
    always_comb begin
        idx       = '0;
        any_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx       = IDW'(i);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pr_arbiter.sv
// Non-preemptive priority arbiter, highest requester index wins, with a
// one-cycle turnaround gap after every grant.
// Optional: define GRANT_TIMEOUT_EN to force-revoke grants held MAX_HOLD cycles.
module pr_arbiter
    import pr_arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int IDW      = $clog2(N_REQ),
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   gnt_id,
    output logic             gnt_valid,
    output logic             busy,
    output logic             timeout
);

    if (MAX_HOLD < 2) begin : g_bad_hold
        $error("pr_arbiter: MAX_HOLD must be >= 2");
    end

    arb_state_t       state, state_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic [IDW-1:0]   gnt_id_nxt;
    logic             gnt_valid_nxt, busy_nxt;
    logic [IDW-1:0]   win_id;
    logic             win_any;
    logic             release_now;

    pr_enc_core #(.N(N_REQ), .IDW(IDW)) u_enc (
        .vec       (req),
        .idx       (win_id),
        .any_valid (win_any)
    );

    // Owner gives up the resource by pulsing done or dropping its request.
    assign release_now = done || !req[gnt_id];

`ifdef GRANT_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);
    logic [CW-1:0] hold_cnt, hold_cnt_nxt;
    logic          timeout_nxt;
`endif

    // Next-state and next-output logic; everything holds unless a state acts.
    always_comb begin
        state_nxt     = state;
        gnt_nxt       = gnt;
        gnt_id_nxt    = gnt_id;
        gnt_valid_nxt = gnt_valid;
        busy_nxt      = busy;
`ifdef GRANT_TIMEOUT_EN
        hold_cnt_nxt  = hold_cnt;
        timeout_nxt   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (en && win_any) begin
                    state_nxt          = GRANT;
                    gnt_nxt            = '0;
                    gnt_nxt[win_id]    = 1'b1;
                    gnt_id_nxt         = win_id;
                    gnt_valid_nxt      = 1'b1;
                    busy_nxt           = 1'b1;
`ifdef GRANT_TIMEOUT_EN
                    hold_cnt_nxt       = '0;
`endif
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_nxt     = GAP;
                    gnt_nxt       = '0;
                    gnt_valid_nxt = 1'b0;
`ifdef GRANT_TIMEOUT_EN
                end else if (hold_cnt == CW'(MAX_HOLD - 1)) begin
                    // Limit hit without a release this cycle: revoke.
                    state_nxt     = GAP;
                    gnt_nxt       = '0;
                    gnt_valid_nxt = 1'b0;
                    timeout_nxt   = 1'b1;
                end else begin
                    hold_cnt_nxt  = hold_cnt + 1'b1;
`endif
                end
            end
            GAP: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt     = IDLE;
                gnt_nxt       = '0;
                gnt_valid_nxt = 1'b0;
                busy_nxt      = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops any grant immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            gnt_id    <= gnt_id_nxt;
            gnt_valid <= gnt_valid_nxt;
            busy      <= busy_nxt;
        end
    end

`ifdef GRANT_TIMEOUT_EN
    // Hold counter and the one-cycle revoke pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            hold_cnt <= hold_cnt_nxt;
            timeout  <= timeout_nxt;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pr_arbiter.sv
// Self-checking bench for pr_arbiter: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_pr_arbiter;

    localparam int N   = 8;
    localparam int IDW = 3;
    localparam int MH  = 4;
`ifdef GRANT_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst, en, done;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_valid, busy, timeout;

    int total = 0;
    int bad   = 0;

    // Model: owner index (-1 = nobody), turnaround pending, cycles held.
    int m_owner, m_last, m_hold;
    bit m_gap, m_tmo;

    pr_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid),
        .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int highest(input logic [N-1:0] v);
        for (int i = N - 1; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = 0; m_hold = 0; m_gap = 0; m_tmo = 0;
    endtask

    // One clock of the reference behaviour using the inputs seen at the edge.
    task automatic model_step();
        m_tmo = 0;
        if (m_owner >= 0) begin
            m_hold++;
            if (done || !req[m_owner]) begin
                m_owner = -1; m_gap = 1;
            end else if (TMO && m_hold >= MH) begin
                m_owner = -1; m_gap = 1; m_tmo = 1;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else if (en && req != 0) begin
            m_owner = highest(req); m_last = m_owner; m_hold = 0;
        end
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] eg;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".id"}, 32'(gnt_id), 32'(m_last));
        chk({tag, ".valid"}, 32'(gnt_valid), 32'(m_owner >= 0));
        chk({tag, ".busy"}, 32'(busy), 32'((m_owner >= 0) || m_gap));
        chk({tag, ".tmo"}, 32'(timeout), 32'(m_tmo));
    endtask

    // Advance one clock, update the model, sample after the edge.
    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = '0; done = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst.gnt", 32'(gnt), 32'h0);
        chk("rst.valid", 32'(gnt_valid), 32'h0);
        chk("rst.busy", 32'(busy), 32'h0);
        chk("rst.tmo", 32'(timeout), 32'h0);
        rst = 1'b0;

        // Priority among several requesters.
        en = 1'b1; req = 8'b0010_0110;
        step("prio");
        chk("prio.gnt", 32'(gnt), 32'h20);
        chk("prio.id", 32'(gnt_id), 32'd5);

        // Higher request does not preempt; done releases into a gap.
        req = 8'b1010_0110;
        step("nopre");
        chk("nopre.gnt", 32'(gnt), 32'h20);
        done = 1'b1;
        step("gap");
        done = 1'b0;
        chk("gap.gnt", 32'(gnt), 32'h0);
        chk("gap.busy", 32'(busy), 32'h1);
        step("idle");
        step("regrant");
        chk("regrant.gnt", 32'(gnt), 32'h80);
        chk("regrant.id", 32'(gnt_id), 32'd7);

        // Owner 7 withdraws; owner 2 gets it, then withdraws too.
        req = 8'h04;
        repeat (3) step("to2");
        chk("own2.gnt", 32'(gnt), 32'h04);
        req = 8'h00;
        step("wd");
        chk("wd.busy", 32'(busy), 32'h1);
        chk("wd.gnt", 32'(gnt), 32'h0);
        en = 1'b0; req = 8'h01;
        repeat (3) step("en0");
        chk("en0.gnt", 32'(gnt), 32'h0);
        en = 1'b1;
        step("en1");
        chk("en1.gnt", 32'(gnt), 32'h01);

        // Asynchronous reset in the middle of a grant.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst.gnt", 32'(gnt), 32'h0);
        chk("arst.valid", 32'(gnt_valid), 32'h0);
        chk("arst.busy", 32'(busy), 32'h0);
        model_reset();
        @(negedge clk);
        req = 8'h00; rst = 1'b0;
        step("post_rst");

        // Long hold without release.
        req = 8'h08;
        step("hold1");
`ifdef GRANT_TIMEOUT_EN
        repeat (3) step("holdn");
        chk("hold4.valid", 32'(gnt_valid), 32'h1);
        step("tmo");
        chk("tmo.pulse", 32'(timeout), 32'h1);
        chk("tmo.valid", 32'(gnt_valid), 32'h0);
        step("tmo_idle");
        chk("tmo_idle.tmo", 32'(timeout), 32'h0);
        step("tmo_regrant");
        chk("tmo_regrant.gnt", 32'(gnt), 32'h08);
`else
        repeat (110) step("holdn");
        chk("persist.gnt", 32'(gnt), 32'h08);
        chk("persist.tmo", 32'(timeout), 32'h0);
`endif

        // done on the fourth grant cycle coincides with the limit.
        req = 8'h00;
        repeat (3) step("drain");
        req = 8'h08;
        step("co1");
        repeat (3) step("co_n");
        done = 1'b1;
        step("co_done");
        done = 1'b0;
        chk("co.tmo", 32'(timeout), 32'h0);
        chk("co.busy", 32'(busy), 32'h1);
        chk("co.valid", 32'(gnt_valid), 32'h0);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(3) == 0) req = N'($urandom);
            en   = ($urandom_range(3) != 0);
            done = ($urandom_range(7) == 0);
            step("rnd");
        end
        done = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
